// File: rtl/dps_pkg.sv
// Shared definitions for the DPS timer responder: register offsets,
// CTRL bit positions and IRQ state encodings.
package dps_pkg;

  // Word offsets (iADDR[7:2]) of the mapped registers
  localparam logic [5:0] DPS_REG_ID      = 6'h00;
  localparam logic [5:0] DPS_REG_SIZE    = 6'h01;
  localparam logic [5:0] DPS_REG_CTRL    = 6'h02;
  localparam logic [5:0] DPS_REG_COUNT   = 6'h03;
  localparam logic [5:0] DPS_REG_COMPARE = 6'h04;
  localparam logic [5:0] DPS_REG_STATUS  = 6'h05;

  // CTRL register bit indices
  localparam int DPS_CTRL_EN          = 0;
  localparam int DPS_CTRL_IRQ_EN      = 1;
  localparam int DPS_CTRL_AUTO_RELOAD = 2;

  // Interrupt handshake states
  typedef enum logic [0:0] {
    DPS_IRQ_IDLE     = 1'b0,
    DPS_IRQ_WAIT_ACK = 1'b1
  } dps_irq_state_e;

  // STATUS read value: only MATCH is implemented, upper bits read 0
  function automatic logic [31:0] dps_status_word(input logic match);
    return {31'h0000_0000, match};
  endfunction

endpackage

// File: rtl/dps_timer_core.sv
// Free-running 32-bit counter with compare, optional auto-reload and a
// single-cycle combinational match pulse for the current cycle.
module dps_timer_core
  import dps_pkg::*;
(
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        en,
  input  logic        auto_reload,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match_pulse
);

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic [31:0] count_inc_s;
  logic [31:0] count_next_s;
  logic        match_s;

  // Next count: a bus write beats the increment; a match with reload goes to 0
  always_comb begin
    count_inc_s  = count_r + 32'd1;
    match_s      = 1'b0;
    count_next_s = count_r;
    if (count_we) begin
      count_next_s = wdata;
    end else if (en) begin
      match_s = (count_inc_s == compare_r);
      if (match_s && auto_reload) begin
        count_next_s = 32'h0000_0000;
      end else begin
        count_next_s = count_inc_s;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Counter and compare registers
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      count_r   <= 32'h0000_0000;
      compare_r <= 32'h0000_0000;
    end else begin
      count_r <= count_next_s;
      if (compare_we) begin
        compare_r <= wdata;
      end
    end
  end

  assign count       = count_r;
  assign compare     = compare_r;
  assign match_pulse = match_s;

endmodule

// File: rtl/dps_timer_responder.sv
// DPS bus responder exposing a compare timer: request decode, one-entry
// read-return buffer, STATUS/CTRL registers and the IRQ handshake FSM.
module dps_timer_responder
  import dps_pkg::*;
#(
  parameter logic [31:0] P_DEVICE_ID = 32'h0000_0001,
  parameter logic [31:0] P_IO_SIZE   = 32'h0000_0000,
  parameter logic [5:0]  P_IRQ_NUM   = 6'h00
)(
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ,
  output logic        oBUSY,
  input  logic        iRW,
  input  logic [31:0] iADDR,
  input  logic [31:0] iDATA,
  output logic        oREQ,
  input  logic        iBUSY,
  output logic [31:0] oDATA,
  output logic        oIRQ_REQ,
  output logic [5:0]  oIRQ_NUM,
  input  logic        iIRQ_ACK
);

  logic           accept_s, wr_s, rd_s;
  logic [5:0]     reg_sel_s;
  logic           ctrl_we_s, count_we_s, compare_we_s, status_we_s;
  logic [31:0]    rdata_s;
  logic [2:0]     ctrl_r;
  logic           match_r;
  logic           ret_full_r;
  logic [31:0]    ret_data_r;
  logic [31:0]    count_s, compare_s;
  logic           match_pulse_s;
  logic           irq_event_s;
  dps_irq_state_e irq_state_r, irq_state_next_s;
  logic           irq_pend_r, irq_pend_next_s;
  logic           irq_req_s;
  logic           unused_addr_s;

  assign unused_addr_s = ^{iADDR[31:8], iADDR[1:0]};

  // Request acceptance, register write strobes and read-data mux
  always_comb begin
    accept_s     = iREQ && !ret_full_r;
    wr_s         = accept_s && iRW;
    rd_s         = accept_s && !iRW;
    reg_sel_s    = iADDR[7:2];
    ctrl_we_s    = wr_s && (reg_sel_s == DPS_REG_CTRL);
    count_we_s   = wr_s && (reg_sel_s == DPS_REG_COUNT);
    compare_we_s = wr_s && (reg_sel_s == DPS_REG_COMPARE);
    status_we_s  = wr_s && (reg_sel_s == DPS_REG_STATUS);
    case (reg_sel_s)
      DPS_REG_ID:      rdata_s = P_DEVICE_ID;
      DPS_REG_SIZE:    rdata_s = P_IO_SIZE;
      DPS_REG_CTRL:    rdata_s = {29'h0000_0000, ctrl_r};
      DPS_REG_COUNT:   rdata_s = count_s;
      DPS_REG_COMPARE: rdata_s = compare_s;
      DPS_REG_STATUS:  rdata_s = dps_status_word(match_r);
      default:         rdata_s = 32'h0000_0000;
    endcase
  end

  dps_timer_core u_core (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .en          (ctrl_r[DPS_CTRL_EN]),
    .auto_reload (ctrl_r[DPS_CTRL_AUTO_RELOAD]),
    .count_we    (count_we_s),
    .compare_we  (compare_we_s),
    .wdata       (iDATA),
    .count       (count_s),
    .compare     (compare_s),
    .match_pulse (match_pulse_s)
  );

  // CTRL register and sticky MATCH flag (a new match beats write-1-clear)
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ctrl_r  <= 3'b000;
      match_r <= 1'b0;
    end else begin
      if (ctrl_we_s) begin
        ctrl_r <= iDATA[2:0];
      end
      if (match_pulse_s) begin
        match_r <= 1'b1;
      end else if (status_we_s && iDATA[0]) begin
        match_r <= 1'b0;
      end
    end
  end

  // One-entry read-return buffer; fills on a read, drains when taken
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ret_full_r <= 1'b0;
      ret_data_r <= 32'h0000_0000;
    end else if (rd_s) begin
      ret_full_r <= 1'b1;
      ret_data_r <= rdata_s;
    end else if (ret_full_r && !iBUSY) begin
      ret_full_r <= 1'b0;
    end
  end

  assign oBUSY = ret_full_r;
  assign oREQ  = ret_full_r;
  assign oDATA = ret_data_r;

  // IRQ FSM state register and pending flag
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      irq_state_r <= DPS_IRQ_IDLE;
      irq_pend_r  <= 1'b0;
    end else begin
      irq_state_r <= irq_state_next_s;
      irq_pend_r  <= irq_pend_next_s;
    end
  end

  // IRQ FSM next state; events during WAIT_ACK are remembered in one bit
  always_comb begin
    irq_event_s      = match_pulse_s && ctrl_r[DPS_CTRL_IRQ_EN];
    irq_state_next_s = irq_state_r;
    irq_pend_next_s  = irq_pend_r;
    case (irq_state_r)
      DPS_IRQ_IDLE: begin
        if (irq_pend_r || irq_event_s) begin
          irq_state_next_s = DPS_IRQ_WAIT_ACK;
        end else begin
          irq_state_next_s = DPS_IRQ_IDLE;
        end
        irq_pend_next_s = 1'b0;
      end
      DPS_IRQ_WAIT_ACK: begin
        if (iIRQ_ACK) begin
          irq_state_next_s = DPS_IRQ_IDLE;
        end else begin
          irq_state_next_s = DPS_IRQ_WAIT_ACK;
        end
        irq_pend_next_s = irq_pend_r || irq_event_s;
      end
      default: begin
        irq_state_next_s = DPS_IRQ_IDLE;
        irq_pend_next_s  = 1'b0;
      end
    endcase
  end

  // IRQ FSM outputs: request held for the whole WAIT_ACK state
  always_comb begin
    irq_req_s = (irq_state_r == DPS_IRQ_WAIT_ACK);
  end

  assign oIRQ_REQ = irq_req_s;
  assign oIRQ_NUM = P_IRQ_NUM;

endmodule

// File: tb/tb_dps_timer_responder.sv
// Directed self-checking bench for dps_timer_responder.
module tb_dps_timer_responder;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iREQ = 1'b0;
  logic        oBUSY;
  logic        iRW = 1'b0;
  logic [31:0] iADDR = 32'h0;
  logic [31:0] iDATA = 32'h0;
  logic        oREQ;
  logic        iBUSY = 1'b0;
  logic [31:0] oDATA;
  logic        oIRQ_REQ;
  logic [5:0]  oIRQ_NUM;
  logic        iIRQ_ACK = 1'b0;

  int checks = 0;
  int errors = 0;

  dps_timer_responder #(
    .P_DEVICE_ID (32'h0000_0001),
    .P_IO_SIZE   (32'h0000_0100),
    .P_IRQ_NUM   (6'h00)
  ) dut (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .iREQ     (iREQ),
    .oBUSY    (oBUSY),
    .iRW      (iRW),
    .iADDR    (iADDR),
    .iDATA    (iDATA),
    .oREQ     (oREQ),
    .iBUSY    (iBUSY),
    .oDATA    (oDATA),
    .oIRQ_REQ (oIRQ_REQ),
    .oIRQ_NUM (oIRQ_NUM),
    .iIRQ_ACK (iIRQ_ACK)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    iREQ = 1'b1; iRW = 1'b1; iADDR = addr; iDATA = data;
    step();
    iREQ = 1'b0; iRW = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    iREQ = 1'b1; iRW = 1'b0; iADDR = addr;
    step();
    iREQ = 1'b0;
    check({tag, "_req"}, {31'h0, oREQ}, 32'h1);
    check({tag, "_data"}, oDATA, exp);
    step();
    check({tag, "_done"}, {31'h0, oREQ}, 32'h0);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_busy", {31'h0, oBUSY}, 32'h0);
    check("rst_req", {31'h0, oREQ}, 32'h0);
    check("rst_data", oDATA, 32'h0);
    check("rst_irq", {31'h0, oIRQ_REQ}, 32'h0);
    check("rst_irqnum", {26'h0, oIRQ_NUM}, 32'h0);
    inRESET = 1'b1;
    step();

    // boot read of SIZE: one cycle latency, busy while held
    iREQ = 1'b1; iRW = 1'b0; iADDR = 32'h4;
    check("boot_idle_busy", {31'h0, oBUSY}, 32'h0);
    step();
    iREQ = 1'b0;
    check("boot_req", {31'h0, oREQ}, 32'h1);
    check("boot_data", oDATA, 32'h0000_0100);
    check("boot_busy", {31'h0, oBUSY}, 32'h1);
    step();
    check("boot_done", {31'h0, oREQ}, 32'h0);

    // return backpressure on an ID read; write attempt while busy must be dropped
    iREQ = 1'b1; iRW = 1'b0; iADDR = 32'h0; iBUSY = 1'b1;
    step();
    iRW = 1'b1; iADDR = 32'h10; iDATA = 32'h77;
    for (int i = 0; i < 3; i++) begin
      check("bp_req", {31'h0, oREQ}, 32'h1);
      check("bp_data", oDATA, 32'h0000_0001);
      check("bp_busy", {31'h0, oBUSY}, 32'h1);
      step();
    end
    iREQ = 1'b0; iRW = 1'b0; iBUSY = 1'b0;
    check("bp_req_last", {31'h0, oREQ}, 32'h1);
    check("bp_data_last", oDATA, 32'h0000_0001);
    step();
    check("bp_done", {31'h0, oREQ}, 32'h0);
    check("bp_compare_unchanged", dut.compare_s, 32'h0);

    // timer with auto-reload and IRQ enable, compare = 5
    bus_write(32'h10, 32'h5);
    bus_write(32'h08, 32'h7);
    check("tm_count0", dut.count_s, 32'h0);
    step();
    check("tm_count1", dut.count_s, 32'h1);
    step(); step(); step();
    check("tm_count4", dut.count_s, 32'h4);
    check("tm_nomatch", {31'h0, dut.match_r}, 32'h0);
    check("tm_noirq", {31'h0, oIRQ_REQ}, 32'h0);
    step();
    check("tm_reload", dut.count_s, 32'h0);
    check("tm_match", {31'h0, dut.match_r}, 32'h1);
    check("tm_irq", {31'h0, oIRQ_REQ}, 32'h1);

    // second match while unacknowledged becomes pending
    for (int i = 0; i < 5; i++) step();
    check("tm_reload2", dut.count_s, 32'h0);
    check("co_irq_held", {31'h0, oIRQ_REQ}, 32'h1);
    bus_write(32'h08, 32'h2);
    iIRQ_ACK = 1'b1;
    step();
    iIRQ_ACK = 1'b0;
    check("co_drop", {31'h0, oIRQ_REQ}, 32'h0);
    step();
    check("co_reassert", {31'h0, oIRQ_REQ}, 32'h1);
    iIRQ_ACK = 1'b1;
    step();
    iIRQ_ACK = 1'b0;
    check("co_drop2", {31'h0, oIRQ_REQ}, 32'h0);
    step();
    check("co_once_a", {31'h0, oIRQ_REQ}, 32'h0);
    step();
    check("co_once_b", {31'h0, oIRQ_REQ}, 32'h0);

    // wrap: COUNT = all ones, COMPARE = 0, EN only
    bus_write(32'h08, 32'h0);
    bus_write(32'h10, 32'h0);
    bus_write(32'h0C, 32'hFFFF_FFFF);
    bus_write(32'h14, 32'h1);
    check("wr_cleared", {31'h0, dut.match_r}, 32'h0);
    bus_write(32'h08, 32'h1);
    check("wr_pre", dut.count_s, 32'hFFFF_FFFF);
    step();
    check("wr_wrap", dut.count_s, 32'h0);
    check("wr_match", {31'h0, dut.match_r}, 32'h1);
    check("wr_noirq", {31'h0, oIRQ_REQ}, 32'h0);

    // STATUS write-1-clear on the match cycle loses to the match
    bus_write(32'h08, 32'h0);
    bus_write(32'h10, 32'h3);
    bus_write(32'h0C, 32'h0);
    bus_write(32'h14, 32'h1);
    check("w1c_cleared", {31'h0, dut.match_r}, 32'h0);
    bus_write(32'h08, 32'h1);
    step(); step();
    check("w1c_count2", dut.count_s, 32'h2);
    bus_write(32'h14, 32'h1);
    check("w1c_match_wins", {31'h0, dut.match_r}, 32'h1);
    check("w1c_count3", dut.count_s, 32'h3);

    // unmapped offset: write ignored, reads 0, other registers intact
    bus_write(32'h08, 32'h0);
    bus_write(32'h0C, 32'h1234);
    bus_write(32'h3C, 32'hDEAD_BEEF);
    bus_read("um_3c", 32'h3C, 32'h0);
    bus_read("um_count", 32'h0C, 32'h1234);
    bus_read("um_compare", 32'h10, 32'h3);
    bus_read("um_ctrl", 32'h08, 32'h0);
    bus_read("um_status", 32'h14, 32'h1);
    bus_read("um_id_lowbits", 32'h3, 32'h1);

    // reset in the middle of a held read
    iREQ = 1'b1; iRW = 1'b0; iADDR = 32'h4; iBUSY = 1'b1;
    step();
    iREQ = 1'b0;
    check("mr_req_before", {31'h0, oREQ}, 32'h1);
    #2;
    inRESET = 1'b0;
    #1;
    check("mr_req", {31'h0, oREQ}, 32'h0);
    check("mr_busy", {31'h0, oBUSY}, 32'h0);
    check("mr_data", oDATA, 32'h0);
    check("mr_count", dut.count_s, 32'h0);
    iBUSY = 1'b0;
    step();
    inRESET = 1'b1;
    step();
    check("mr_after", {31'h0, oREQ}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
